// File: rtl/mtr_drv.sv
// mtr_drv: turns signed left/right speed commands into two dead-time
// protected H-bridge PWM pairs on an 11-bit (2048-clock) timebase.
module mtr_drv #(
  parameter int DEAD_CYC = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        lftPWM1,
  output logic        lftPWM2,
  output logic        rghtPWM1,
  output logic        rghtPWM2,
  output logic        pwm_sync
);

  typedef enum logic [1:0] {
    DEAD = 2'd0,
    DRV1 = 2'd1,
    DRV2 = 2'd2
  } ch_state_t;

  localparam logic [5:0]  DC_LAST = 6'(DEAD_CYC - 1);
  localparam logic [10:0] CNT_MAX = 11'h7FF;

  logic [10:0] cnt;
  logic [10:0] lft_duty;
  logic [10:0] rght_duty;
  logic [1:0]  raw;
  logic [1:0]  pwm1;
  logic [1:0]  pwm2;
  ch_state_t   state     [2];
  ch_state_t   nxt_state [2];
  logic [5:0]  dc        [2];
  logic [5:0]  nxt_dc    [2];

  // Free-running timebase, shadow duty load at the period boundary, and the
  // sync pulse that marks cnt==0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lft_duty  <= 11'h400;
      rght_duty <= 11'h400;
      pwm_sync  <= 1'b0;
    end else begin
      cnt      <= cnt + 11'd1;
      pwm_sync <= (cnt == CNT_MAX);
      if (cnt == CNT_MAX) begin
        lft_duty  <= {~lft_spd[10], lft_spd[9:0]};
        rght_duty <= {~rght_spd[10], rght_spd[9:0]};
      end
    end
  end

  // Raw (pre dead-time) PWM for each side; index 0 is left, 1 is right.
  always_comb begin
    raw[0] = (cnt < lft_duty);
    raw[1] = (cnt < rght_duty);
  end

  // Channel FSM next state: a drive is only entered after a full dead interval.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      nxt_state[i] = state[i];
      nxt_dc[i]    = dc[i];
      case (state[i])
        DEAD: begin
          nxt_dc[i] = dc[i] + 6'd1;
          if (dc[i] == DC_LAST) begin
            nxt_state[i] = raw[i] ? DRV1 : DRV2;
            nxt_dc[i]    = '0;
          end
        end
        DRV1: begin
          if (!raw[i]) begin
            nxt_state[i] = DEAD;
            nxt_dc[i]    = '0;
          end
        end
        DRV2: begin
          if (raw[i]) begin
            nxt_state[i] = DEAD;
            nxt_dc[i]    = '0;
          end
        end
        default: begin
          nxt_state[i] = DEAD;
          nxt_dc[i]    = '0;
        end
      endcase
    end
  end

  // State registers plus output flops decoded from the next state, so the pins
  // track the state exactly and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= DEAD;
        dc[i]    <= '0;
      end
      pwm1 <= '0;
      pwm2 <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= nxt_state[i];
        dc[i]    <= nxt_dc[i];
        pwm1[i]  <= (nxt_state[i] == DRV1);
        pwm2[i]  <= (nxt_state[i] == DRV2);
      end
    end
  end

  assign lftPWM1  = pwm1[0];
  assign lftPWM2  = pwm2[0];
  assign rghtPWM1 = pwm1[1];
  assign rghtPWM2 = pwm2[1];

endmodule
